// File: rtl/riscv_dmem_ctrl.sv
// Data RAM sequencer/arbiter: shares a single-port synchronous-read RAM between
// the CPU load/store unit and the boot loader, with store lane alignment and load extension.
module riscv_dmem_ctrl #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [1:0]        i_cpu_size,
  input  logic              i_cpu_unsigned,
  input  logic [31:0]       i_cpu_addr,
  input  logic [31:0]       i_cpu_wdata,
  output logic              o_cpu_ready,
  output logic [31:0]       o_cpu_rdata,
  output logic              o_cpu_misalign,
  input  logic              i_ldr_req,
  input  logic [31:0]       i_ldr_addr,
  input  logic [31:0]       i_ldr_wdata,
  output logic              o_ldr_gnt,
  output logic [3:0]        o_ram_wea,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [31:0]       o_ram_din,
  input  logic [31:0]       i_ram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_isLdr;
  logic              r_we;
  logic              r_mis;
  logic              r_uns;
  logic [1:0]        r_size;
  logic [1:0]        r_addrLo;
  logic [1:0]        r_cnt;
  logic [3:0]        r_wea;
  logic [ADDR_W-1:0] r_ramAddr;
  logic [31:0]       r_ramDin;
  logic [31:0]       r_rdata;

  logic              w_cpuMis;
  logic [3:0]        w_cpuWea;
  logic [31:0]       w_cpuDin;
  logic [31:0]       w_ext;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic              w_unused;

  assign w_unused = ^{i_cpu_addr[31:ADDR_W+2], i_ldr_addr[31:ADDR_W+2], i_ldr_addr[1:0]};

  assign w_cpuMis = (i_cpu_size == 2'b11) ||
                    (i_cpu_size == 2'b01 && i_cpu_addr[0]) ||
                    (i_cpu_size == 2'b10 && i_cpu_addr[1:0] != 2'b00);

  always_comb begin
    w_cpuWea = 4'b1111;
    w_cpuDin = i_cpu_wdata;
    case (i_cpu_size)
      2'b00: begin
        w_cpuWea = 4'b0001 << i_cpu_addr[1:0];
        w_cpuDin = {4{i_cpu_wdata[7:0]}};
      end
      2'b01: begin
        w_cpuWea = i_cpu_addr[1] ? 4'b1100 : 4'b0011;
        w_cpuDin = {2{i_cpu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and extension use the fields latched at request time.
  always_comb begin
    w_byte = i_ram_dout[{r_addrLo, 3'b000} +: 8];
    w_half = i_ram_dout[{r_addrLo[1], 4'b0000} +: 16];
    w_ext  = i_ram_dout;
    case (r_size)
      2'b00:   w_ext = r_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ext = r_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    o_ram_wea      = 4'b0000;
    o_cpu_ready    = 1'b0;
    o_cpu_misalign = 1'b0;
    o_cpu_rdata    = 32'b0;
    o_ldr_gnt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_ldr_req)      w_next = S_ISSUE;
        else if (i_cpu_req) w_next = w_cpuMis ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        o_ram_wea   = r_wea;
        o_ldr_gnt   = r_isLdr;
        o_cpu_ready = !r_isLdr && r_we;
        w_next      = (r_isLdr || r_we) ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 2'd0) w_next = S_RESP;
      end
      S_RESP: begin
        o_cpu_ready    = 1'b1;
        o_cpu_misalign = r_mis;
        o_cpu_rdata    = r_mis ? 32'b0 : r_rdata;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Rejected accesses never touch the RAM address/data registers, so they keep their last value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_isLdr   <= 1'b0;
      r_we      <= 1'b0;
      r_mis     <= 1'b0;
      r_uns     <= 1'b0;
      r_size    <= 2'b00;
      r_addrLo  <= 2'b00;
      r_cnt     <= 2'd0;
      r_wea     <= 4'b0000;
      r_ramAddr <= '0;
      r_ramDin  <= 32'b0;
      r_rdata   <= 32'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_ldr_req) begin
            r_isLdr   <= 1'b1;
            r_we      <= 1'b1;
            r_mis     <= 1'b0;
            r_wea     <= 4'b1111;
            r_ramAddr <= i_ldr_addr[ADDR_W+1:2];
            r_ramDin  <= i_ldr_wdata;
          end else if (i_cpu_req) begin
            r_isLdr  <= 1'b0;
            r_we     <= i_cpu_we;
            r_mis    <= w_cpuMis;
            r_uns    <= i_cpu_unsigned;
            r_size   <= i_cpu_size;
            r_addrLo <= i_cpu_addr[1:0];
            if (!w_cpuMis) begin
              r_ramAddr <= i_cpu_addr[ADDR_W+1:2];
              r_wea     <= i_cpu_we ? w_cpuWea : 4'b0000;
              if (i_cpu_we) r_ramDin <= w_cpuDin;
            end
          end
        end
        S_ISSUE: begin
          if (!r_isLdr && !r_we) r_cnt <= LAT_M1;
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) r_rdata <= w_ext;
          else               r_cnt   <= r_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_ram_addr = r_ramAddr;
  assign o_ram_din  = r_ramDin;

endmodule
